// File: rtl/spi_peripheral.sv
// SPI mode-0 target front end. Oversamples CS, SCLK and COPI in the system
// clock domain, decodes the first byte of each frame as the opcode, delivers
// later bytes as operand pulses and shifts register responses out on CIPO.
//
// Handshake: opcode_valid is a level that holds from opcode completion until
// the frame ends, and it acts as the register enable. operand_valid is a
// single-cycle pulse per completed operand byte. There is no ready/backpressure:
// the consumer must take each operand in the cycle it is pulsed. The response
// is qualified by response_valid and is sampled only at byte-start SCLK falls.
module spi_peripheral (
  input  logic       system_clock,
  input  logic       system_reset_n,
  input  logic       spi_select_in,
  input  logic       spi_clock_in,
  input  logic       spi_data_in,
  output logic       spi_data_out,
  output logic [7:0] opcode,
  output logic       opcode_valid,
  output logic [7:0] operand,
  output logic       operand_valid,
  input  logic [7:0] response,
  input  logic       response_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPCODE = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t     state_q, state_d;

  // Synchronizer stages. CS resets low so that a frame already in progress
  // when reset is released is ignored until CS is genuinely seen high.
  logic       cs_meta, cs_sync;
  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       copi_meta, copi_sync;

  logic       sclk_rise, sclk_fall;
  logic [7:0] rx_shift;
  logic [7:0] tx_load;

  logic       seen_high_q, seen_high_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       cipo_q, cipo_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       operand_valid_q, operand_valid_d;

  // Two-flop synchronizers; COPI shares the SCLK depth so both stay aligned.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      copi_meta <= 1'b0;
      copi_sync <= 1'b0;
    end else begin
      cs_meta   <= spi_select_in;
      cs_sync   <= cs_meta;
      sclk_meta <= spi_clock_in;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      copi_meta <= spi_data_in;
      copi_sync <= copi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign rx_shift  = {rx_q[6:0], copi_sync};
  assign tx_load   = response_valid ? response : 8'h00;

  // FSM state register.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode; CS high always wins over SCLK edges.
  always_comb begin
    state_d         = state_q;
    seen_high_d     = seen_high_q | cs_sync;
    bit_cnt_d       = bit_cnt_q;
    rx_d            = rx_q;
    tx_d            = tx_q;
    cipo_d          = cipo_q;
    opcode_d        = opcode_q;
    operand_d       = operand_q;
    operand_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        cipo_d    = 1'b0;
        if (!cs_sync && seen_high_q) begin
          state_d = ST_OPCODE;
        end
      end

      ST_OPCODE: begin
        cipo_d = 1'b0;
        if (cs_sync) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            opcode_d = rx_shift;
            state_d  = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (cs_sync) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          cipo_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            operand_d       = rx_shift;
            operand_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) begin
            // Byte start: capture the selected register's response once.
            tx_d   = tx_load;
            cipo_d = tx_load[7];
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            cipo_d = tx_q[6];
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        cipo_d    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      seen_high_q     <= 1'b0;
      bit_cnt_q       <= 3'd0;
      rx_q            <= 8'h00;
      tx_q            <= 8'h00;
      cipo_q          <= 1'b0;
      opcode_q        <= 8'h00;
      operand_q       <= 8'h00;
      operand_valid_q <= 1'b0;
    end else begin
      seen_high_q     <= seen_high_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_q            <= rx_d;
      tx_q            <= tx_d;
      cipo_q          <= cipo_d;
      opcode_q        <= opcode_d;
      operand_q       <= operand_d;
      operand_valid_q <= operand_valid_d;
    end
  end

  assign spi_data_out  = cipo_q;
  assign opcode        = opcode_q;
  assign opcode_valid  = (state_q == ST_DATA);
  assign operand       = operand_q;
  assign operand_valid = operand_valid_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: drives SPI mode-0 frames at clk/8,
// models a register that returns "Test", and checks decode, CIPO data,
// output latencies, aborts, mid-frame reset and CS/SCLK collisions.
module tb_spi_peripheral;

  logic       system_clock;
  logic       system_reset_n;
  logic       spi_select_in;
  logic       spi_clock_in;
  logic       spi_data_in;
  logic       spi_data_out;
  logic [7:0] opcode;
  logic       opcode_valid;
  logic [7:0] operand;
  logic       operand_valid;
  logic [7:0] response;
  logic       response_valid;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int last_rise_cyc = 0;
  int last_cs_rise_cyc = 0;
  int ov_rises = 0;
  int opv_pulses = 0;
  logic ov_q = 1'b0;

  logic [7:0] exp_q[$];

  // Register model returning "Test", advancing on operand_valid.
  logic [7:0] msg [4];
  int         msg_idx = 0;
  logic       resp_en = 1'b0;

  spi_peripheral dut (
    .system_clock   (system_clock),
    .system_reset_n (system_reset_n),
    .spi_select_in  (spi_select_in),
    .spi_clock_in   (spi_clock_in),
    .spi_data_in    (spi_data_in),
    .spi_data_out   (spi_data_out),
    .opcode         (opcode),
    .opcode_valid   (opcode_valid),
    .operand        (operand),
    .operand_valid  (operand_valid),
    .response       (response),
    .response_valid (response_valid)
  );

  // Clock and cycle counter.
  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  always @(posedge system_clock) cyc <= cyc + 1;

  initial begin
    msg[0] = 8'h54;
    msg[1] = 8'h65;
    msg[2] = 8'h73;
    msg[3] = 8'h74;
  end

  always @(posedge system_clock) begin
    if (!opcode_valid) msg_idx <= 0;
    else if (operand_valid && msg_idx < 3) msg_idx <= msg_idx + 1;
  end

  assign response       = msg[msg_idx];
  assign response_valid = resp_en;

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Output monitor and operand scoreboard.
  always @(negedge system_clock) begin
    if (system_reset_n) begin
      if (opcode_valid && !ov_q) begin
        ov_rises++;
        check_eq("opcode_valid_rise_lat", cyc - last_rise_cyc, 3);
      end
      if (!opcode_valid && ov_q) begin
        check_eq("opcode_valid_fall_lat", cyc - last_cs_rise_cyc, 3);
      end
      if (operand_valid) begin
        opv_pulses++;
        check_eq("operand_valid_lat", cyc - last_rise_cyc, 3);
        if (exp_q.size() > 0) check_eq("operand", {24'd0, operand}, {24'd0, exp_q.pop_front()});
      end
    end
    ov_q = opcode_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic miso);
    spi_data_in = b;
    tick(4);
    miso = spi_data_out;
    spi_clock_in = 1'b1;
    last_rise_cyc = cyc;
    tick(4);
    spi_clock_in = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mosi[i], b);
      miso[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_select_in = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_select_in = 1'b1;
    last_cs_rise_cyc = cyc;
    tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic       b;
    int         opv_base;
    int         ov_base;

    system_reset_n = 1'b0;
    spi_select_in  = 1'b1;
    spi_clock_in   = 1'b0;
    spi_data_in    = 1'b0;
    tick(3);

    // Reset values.
    check_eq("rst_cipo", {31'd0, spi_data_out}, 0);
    check_eq("rst_opcode", {24'd0, opcode}, 0);
    check_eq("rst_opcode_valid", {31'd0, opcode_valid}, 0);
    check_eq("rst_operand", {24'd0, operand}, 0);
    check_eq("rst_operand_valid", {31'd0, operand_valid}, 0);
    system_reset_n = 1'b1;
    tick(6);

    // Basic frame: opcode 0xA5, operand 0x3C.
    opv_base = opv_pulses;
    exp_q.push_back(8'h3C);
    cs_low();
    spi_byte(8'hA5, rx);
    check_eq("cipo_during_opcode", {24'd0, rx}, 0);
    check_eq("opcode_a5", {24'd0, opcode}, 32'hA5);
    check_eq("opcode_valid_in_frame", {31'd0, opcode_valid}, 1);
    spi_byte(8'h3C, rx);
    cs_high();
    check_eq("frame1_opv_count", opv_pulses - opv_base, 1);
    check_eq("frame1_ov_rises", ov_rises, 1);
    check_eq("frame1_ov_after", {31'd0, opcode_valid}, 0);
    check_eq("frame1_opcode_kept", {24'd0, opcode}, 32'hA5);

    // Register read: opcode 0x01 plus four dummy bytes returns "Test".
    resp_en = 1'b1;
    cs_low();
    spi_byte(8'h01, rx);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hF0 + 8'(i));
      spi_byte(8'hF0 + 8'(i), rx);
      check_eq("cipo_test_byte", {24'd0, rx}, {24'd0, msg[i]});
    end
    cs_high();

    // Response not valid: CIPO reads zeros.
    resp_en = 1'b0;
    cs_low();
    spi_byte(8'h10, rx);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'hC3);
      spi_byte(8'hC3, rx);
      check_eq("cipo_no_resp", {24'd0, rx}, 0);
    end
    cs_high();
    resp_en = 1'b1;

    // Abort after 5 bits of the second byte, then a clean frame.
    opv_base = opv_pulses;
    cs_low();
    spi_byte(8'h33, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    cs_high();
    check_eq("abort_no_opv", opv_pulses - opv_base, 0);
    check_eq("abort_operand_kept", {24'd0, operand}, 32'hC3);
    check_eq("abort_ov_low", {31'd0, opcode_valid}, 0);
    exp_q.push_back(8'h81);
    cs_low();
    spi_byte(8'h22, rx);
    check_eq("opcode_22", {24'd0, opcode}, 32'h22);
    spi_byte(8'h81, rx);
    cs_high();
    check_eq("realign_opv", opv_pulses - opv_base, 1);

    // Reset pulsed during the third opcode bit; rest of frame ignored.
    opv_base = opv_pulses;
    ov_base  = ov_rises;
    cs_low();
    spi_bit(1'b0, b);
    spi_bit(1'b1, b);
    spi_data_in = 1'b1;
    tick(2);
    system_reset_n = 1'b0;
    tick(2);
    check_eq("midrst_opcode", {24'd0, opcode}, 0);
    check_eq("midrst_operand", {24'd0, operand}, 0);
    check_eq("midrst_cipo", {31'd0, spi_data_out}, 0);
    check_eq("midrst_ov", {31'd0, opcode_valid}, 0);
    system_reset_n = 1'b1;
    tick(2);
    spi_clock_in = 1'b1;
    last_rise_cyc = cyc;
    tick(4);
    spi_clock_in = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    spi_byte(8'h99, rx);
    check_eq("midrst_no_ov", ov_rises - ov_base, 0);
    cs_high();
    check_eq("midrst_no_opv", opv_pulses - opv_base, 0);
    exp_q.push_back(8'h42);
    cs_low();
    spi_byte(8'h5A, rx);
    check_eq("opcode_5a", {24'd0, opcode}, 32'h5A);
    spi_byte(8'h42, rx);
    cs_high();
    check_eq("after_rst_ov", ov_rises - ov_base, 1);
    check_eq("after_rst_opv", opv_pulses - opv_base, 1);

    // CS rise coincides with the 8th SCLK rise of an operand byte.
    opv_base = opv_pulses;
    cs_low();
    spi_byte(8'h77, rx);
    for (int i = 0; i < 7; i++) spi_bit(1'b0, b);
    spi_data_in = 1'b1;
    tick(4);
    spi_clock_in  = 1'b1;
    spi_select_in = 1'b1;
    last_rise_cyc = cyc;
    last_cs_rise_cyc = cyc;
    tick(4);
    spi_clock_in = 1'b0;
    tick(8);
    check_eq("collide_no_opv", opv_pulses - opv_base, 0);
    check_eq("collide_operand_kept", {24'd0, operand}, 32'h42);
    check_eq("collide_ov_low", {31'd0, opcode_valid}, 0);

    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
